// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // STATUS word bit positions
    localparam int FULL    = 0;
    localparam int EMPTY   = 1;
    localparam int BUSY    = 2;
    localparam int OVF     = 3;
    localparam int CNT_LSB = 8;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; pointers wrap naturally, count is one bit wider.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from registered count, so a same-cycle pop never frees room for a push.
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a FIFO drained by a serializer FSM,
// STATUS reads report full/empty/busy/overflow and the FIFO count.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_00F8,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        Wr,
    input  logic [31:0] WriteData,
    output logic        rd_hit,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        tx_idle
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

    logic             hit_data;
    logic             hit_stat;
    logic             push_req;
    logic             ovf;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_head;
    logic             fifo_pop;

    uart_state_t      state, state_d;
    logic [BAUD_W-1:0] baud, baud_d;
    logic [2:0]       bit_cnt, bit_d;
    logic [7:0]       shreg, shreg_d;
    logic             tx_d;
    logic             unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    assign hit_data = (Address == BASE_ADDR + TXDATA_OFS);
    assign hit_stat = (Address == BASE_ADDR + STATUS_OFS);
    assign push_req = Wr && hit_data;
    assign rd_hit   = hit_data || hit_stat;
    assign tx_idle  = fifo_empty && (state == IDLE);

    always_comb begin
        ReadData = '0;
        if (hit_stat) begin
            ReadData[FULL]                 = fifo_full;
            ReadData[EMPTY]                = fifo_empty;
            ReadData[BUSY]                 = (state != IDLE);
            ReadData[OVF]                  = ovf;
            ReadData[CNT_LSB +: CNT_W]     = fifo_count;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .din   (WriteData[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A dropped store and a clear can never coincide: they decode different addresses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (push_req && fifo_full) begin
            ovf <= 1'b1;
        end else if (Wr && hit_stat && WriteData[OVF]) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_cnt <= bit_d;
            shreg   <= shreg_d;
            tx      <= tx_d;
        end
    end

    always_comb begin
        state_d  = state;
        baud_d   = baud;
        bit_d    = bit_cnt;
        shreg_d  = shreg;
        fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                    baud_d   = BAUD_LOAD;
                    shreg_d  = fifo_head;
                end
            end
            START: begin
                if (baud == '0) begin
                    state_d = DATA;
                    baud_d  = BAUD_LOAD;
                end else begin
                    baud_d = baud - 1'b1;
                end
            end
            DATA: begin
                if (baud == '0) begin
                    baud_d  = BAUD_LOAD;
                    shreg_d = {1'b0, shreg[7:1]};
                    bit_d   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud - 1'b1;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more bytes are queued.
                if (baud == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = START;
                        baud_d   = BAUD_LOAD;
                        shreg_d  = fifo_head;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        if (state_d == START)     tx_d = 1'b0;
        else if (state_d == DATA) tx_d = shreg_d[0];
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_00F8;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] STA  = BASE + 32'd4;
    localparam logic [31:0] NOHIT = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = NOHIT;
    logic        Wr = 1'b0;
    logic [31:0] WriteData = '0;
    logic        rd_hit;
    logic [31:0] ReadData;
    logic        tx;
    logic        tx_idle;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .Address   (Address),
        .Wr        (Wr),
        .WriteData (WriteData),
        .rd_hit    (rd_hit),
        .ReadData  (ReadData),
        .tx        (tx),
        .tx_idle   (tx_idle)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        Wr        = 1'b1;
        tick();
        Wr        = 1'b0;
        WriteData = '0;
        Address   = NOHIT;
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp);
        Address = STA;
        #1;
        check(tag, ReadData, exp);
        check({tag, "_hit"}, {31'b0, rd_hit}, 32'd1);
    endtask

    function automatic logic fbit(input logic [7:0] d, input int idx);
        if (idx == 0)      return 1'b0;
        else if (idx == 9) return 1'b1;
        else               return d[idx-1];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pair [2];
        pair[0] = 8'hA5;
        pair[1] = 8'h3C;

        // Reset state while reset is held
        repeat (2) @(posedge clock);
        #1;
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_tx_idle", {31'b0, tx_idle}, 32'd1);
        check_status("rst_status", 32'h0000_0002);
        reset = 1'b1;
        tick();

        // Address decode
        check_status("idle_status", 32'h0000_0002);
        Address = TXD;
        #1;
        check("txdata_hit", {31'b0, rd_hit}, 32'd1);
        check("txdata_read", ReadData, 32'd0);
        Address = BASE - 32'd4;
        #1;
        check("below_base_hit", {31'b0, rd_hit}, 32'd0);
        check("below_base_read", ReadData, 32'd0);

        // Single frame 0x55
        write(TXD, 32'h0000_0055);
        check("f55_tx_at_push", {31'b0, tx}, 32'd1);
        check("f55_idle_at_push", {31'b0, tx_idle}, 32'd0);
        check_status("f55_status_push", 32'h0000_0100);
        for (int k = 1; k <= 40; k++) begin
            tick();
            check($sformatf("f55_tx_k%0d", k), {31'b0, tx}, {31'b0, fbit(8'h55, (k-1)/4)});
            if (k == 40) check("f55_idle_last", {31'b0, tx_idle}, 32'd0);
        end
        tick();
        check("f55_idle_after", {31'b0, tx_idle}, 32'd1);
        check("f55_tx_after", {31'b0, tx}, 32'd1);

        // Back-to-back frames 0xA5, 0x3C
        write(TXD, 32'h0000_00A5);
        write(TXD, 32'h0000_003C);
        check_status("b2b_status", 32'h0000_0104);
        for (int k = 1; k <= 80; k++) begin
            check($sformatf("b2b_tx_k%0d", k), {31'b0, tx},
                  {31'b0, fbit(pair[(k-1)/40], ((k-1)%40)/4)});
            if (k == 80) check("b2b_idle_last", {31'b0, tx_idle}, 32'd0);
            tick();
        end
        check("b2b_idle_after", {31'b0, tx_idle}, 32'd1);

        // Fill: 9 accepted writes (first pops), 10th overflows
        for (int i = 0; i < 10; i++) write(TXD, 32'(i + 16));
        check_status("fill_status", 32'h0000_080D);
        write(STA, 32'h0000_0008);
        check_status("ovf_clear_status", 32'h0000_0805);

        // Store coinciding with STOP->START pop while full is still dropped
        repeat (30) tick();
        check_status("pre_pop_status", 32'h0000_0805);
        write(TXD, 32'h0000_00EE);
        check_status("pop_push_status", 32'h0000_070C);
        check("pop_push_tx", {31'b0, tx}, 32'd0);

        // Reset during DATA bit 3
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        check_status("reset2_status", 32'h0000_0002);
        write(TXD, 32'h0000_0000);
        write(TXD, 32'h0000_00FF);
        repeat (17) tick();
        check("bit3_tx_low", {31'b0, tx}, 32'd0);
        check_status("bit3_status", 32'h0000_0104);
        reset = 1'b0;
        #1;
        check("midreset_tx", {31'b0, tx}, 32'd1);
        reset = 1'b1;
        check_status("midreset_status", 32'h0000_0002);
        tick();
        check_status("midreset_status_next", 32'h0000_0002);
        check("midreset_tx_next", {31'b0, tx}, 32'd1);
        check("midreset_idle_next", {31'b0, tx_idle}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the CPU's data-memory path, downstream of the CPU's address mux and the `Wr` strobe. Stores to its data address enqueue bytes into an internal FIFO; a serializer drains the FIFO onto a single `tx` line as 8N1 frames. A status word is returned on reads so software can poll for space and completion.

## Interface
Parameters:
- `BASE_ADDR`, default `32'h0000_00F8`: TXDATA register address. STATUS is at `BASE_ADDR+4`.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, minimum 2.
- `FIFO_DEPTH`, default 8: number of bytes; must be a power of two, range 2–16.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `Address` in 32: byte address, taken from the IorD mux output.
- `Wr` in 1: memory write strobe, high for one cycle per store.
- `WriteData` in 32: store data from the StoreSize output.
- `rd_hit` out 1: combinational; high when `Address` equals TXDATA or STATUS. The CPU uses it to select `ReadData` over memory.
- `ReadData` out 32: combinational. STATUS reads return the status word; TXDATA reads return 0; all other addresses return 0.
- `tx` out 1: serial line, idle high.
- `tx_idle` out 1: high when the FIFO is empty and the FSM is in IDLE.

## Operation
- **TXDATA write** (`Wr`=1, `Address`=BASE_ADDR):
  - Push `WriteData[7:0]` if the FIFO is not full at that cycle.
  - Otherwise drop the byte and set the sticky `ovf` flag.
  - A same-cycle pop does not free space for the push.
- **STATUS write** (`Wr`=1, `Address`=BASE_ADDR+4): `WriteData[3]`=1 clears `ovf`. All other bits are ignored.
- **STATUS word:**
  - bit0 full, bit1 empty, bit2 busy (FSM not in IDLE), bit3 ovf.
  - bits[12:8] FIFO count.
  - All other bits 0.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is not empty. This pops the head byte into the shift register and loads the baud counter.
  - START drives `tx`=0 for CLKS_PER_BIT cycles, then goes to DATA.
  - DATA drives 8 bits LSB first, each for CLKS_PER_BIT cycles. A 3-bit counter wraps 7→0 on exit to STOP.
  - STOP drives `tx`=1 for CLKS_PER_BIT cycles. At the end:
    - if the FIFO is not empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- **Baud counter:** counts CLKS_PER_BIT−1 down to 0; the bit advances at 0. Width is $clog2(CLKS_PER_BIT).
- **FIFO:**
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo depth.
  - The count is one bit wider.
  - Push and pop in the same cycle leave the count unchanged.
- **Reset values:**
  - `tx`=1, `tx_idle`=1, `rd_hit`/`ReadData` reflect `Address` only.
  - FIFO empty, pointers 0, `ovf`=0, FSM IDLE, counters 0.
- **Reset mid-frame:** `tx` returns to 1 immediately (asynchronous). Queued bytes are discarded.

## Timing
- A push registered at edge E0 makes the FIFO non-empty after E0.
- The FSM leaves IDLE at E1, and `tx` goes low after E1. Write-to-start-bit latency is 1 cycle after the push edge.
- Frame length is exactly 10×CLKS_PER_BIT cycles. Back-to-back frames have no gap.
- Status bits reflect register state after the latest edge. There is no read latency: `ReadData` is combinational.
- The count is observable via STATUS in the cycle after a push.
- `tx_idle` rises in the cycle after the final stop bit completes.

## Structure
- Package `uart_pkg`:
  - state enum `uart_state_t` {IDLE, START, DATA, STOP};
  - STATUS bit-index constants (FULL=0, EMPTY=1, BUSY=2, OVF=3, CNT_LSB=8);
  - offset constants TXDATA_OFS=0, STATUS_OFS=4.
- Sub-module `sync_fifo`, parameterised by width and depth, with push/pop/full/empty/count ports. It holds the storage and pointers.
- The top level contains address decode, the `ovf` flag, the FSM, the baud counter, the bit counter and the shift register.

## Test plan
- Reset, then write 0x55 to TXDATA (CLKS_PER_BIT=4):
  - `tx` goes low 1 cycle after the push edge.
  - Pattern is 0,1,0,1,0,1,0,1,0,1, each 4 cycles.
  - `tx_idle` rises 40 cycles after the start bit begins.
- Write 0xA5 then 0x3C on consecutive stores: the two frames are contiguous, 80 cycles total, with no extra idle cycle between the stop bit and the second start bit.
- Fill with 9 writes while `tx` is stalled by a large CLKS_PER_BIT:
  - the first byte pops, leaving 8 queued;
  - the 10th write sets `ovf`;
  - STATUS reads full=1, ovf=1, count=8;
  - writing 0x8 to STATUS clears `ovf`.
- Read STATUS with the FIFO empty and idle: `rd_hit`=1 and `ReadData`=0x0000_0002. `Address`=BASE_ADDR−4 gives `rd_hit`=0.
- Assert `reset` low during DATA bit 3: `tx`=1 immediately, and STATUS after release is 0x0000_0002.
- Push coinciding with the STOP→START pop when count=FIFO_DEPTH: the byte is dropped, `ovf`=1, and count becomes DEPTH−1.
